// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage (master) drives the address; the memory (slave) returns the
// word at that address combinationally in the same cycle.
interface if_stage_if #(
   parameter int SIZE = 32
);
   logic [SIZE-1:0] imem_addr;
   logic [SIZE-1:0] imem_data;

   modport master (
      output imem_addr,
      input  imem_data
   );

   modport slave (
      input  imem_addr,
      output imem_data
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Fetches from a combinational instruction memory addressed straight from the PC.
// Supports data-stall hold, EX-stage redirect (redirect beats stall) and optional
// CPI counters compiled in with the IF_PERF_CNT_EN macro; without it the counter
// outputs are tied to zero and no counter registers exist.
module if_stage #(
   parameter int              SIZE     = 32,
   parameter logic [SIZE-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dstall,
   input  logic             branch_taken,
   input  logic [SIZE-1:0]  branch_target,
   if_stage_if.master       imem,
   output logic [SIZE-1:0]  Instruction,
   output logic [SIZE-1:0]  PC4,
   output logic             valid,
   output logic [SIZE-1:0]  fetch_count,
   output logic [SIZE-1:0]  stall_count
);

   // Word alignment mask: the two low PC bits are always zero.
   localparam logic [SIZE-1:0] PC_MASK          = {{(SIZE-2){1'b1}}, 2'b00};
   localparam logic [SIZE-1:0] RESET_PC_ALIGNED = RESET_PC & PC_MASK;

   logic [SIZE-1:0] pc;
   logic [SIZE-1:0] pc_next;

   // Sequential fetch address; wraps naturally modulo 2^SIZE.
   assign pc_next        = pc + SIZE'(4);
   assign imem.imem_addr = pc;

   // PC and IF/ID register: redirect first, then stall hold, else normal fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC_ALIGNED;
         Instruction <= '0;
         PC4         <= '0;
         valid       <= 1'b0;
      end else if (branch_taken) begin
         pc          <= branch_target & PC_MASK;
         Instruction <= '0;
         PC4         <= '0;
         valid       <= 1'b0;
      end else if (!dstall) begin
         pc          <= pc_next;
         Instruction <= imem.imem_data;
         PC4         <= pc_next;
         valid       <= 1'b1;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic            fetch_cycle;
   logic            stall_cycle;
   logic [SIZE-1:0] fetch_cnt;
   logic [SIZE-1:0] stall_cnt;

   // A redirect cycle counts as neither a fetch nor a stall.
   assign fetch_cycle = !branch_taken && !dstall;
   assign stall_cycle = !branch_taken && dstall;

   // Saturating CPI counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (fetch_cycle && (fetch_cnt != '1)) begin
            fetch_cnt <= fetch_cnt + SIZE'(1);
         end
         if (stall_cycle && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + SIZE'(1);
         end
      end
   end

   assign fetch_count = fetch_cnt;
   assign stall_count = stall_cnt;
`else
   assign fetch_count = '0;
   assign stall_count = '0;
`endif

endmodule
